// File: rtl/complete_stage.sv
// complete_stage: buffers ALU/MEM results in per-pipe FIFOs and issues one registered completion pulse per cycle.
// Define COMPL_BRANCH_PRIO_EN to let a redirecting ALU head win over MEM without moving the round-robin pointer.
module complete_stage #(
   parameter int ROB_BITS   = 4,
   parameter int PR_BITS    = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_valid,
   output logic                        alu_ready,
   input  logic [ROB_BITS-1:0]         alu_rob_num,
   input  logic [PR_BITS-1:0]          alu_p_rd,
   input  logic                        alu_RegDest,
   input  logic                        alu_changeFlow,
   input  logic [31:0]                 alu_jb_addr,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [ROB_BITS-1:0]         mem_rob_num,
   input  logic [PR_BITS-1:0]          mem_p_rd,
   input  logic                        mem_RegDest,
   input  logic                        recover,
   input  logic [ROB_BITS-1:0]         flush_rob_num,
   output logic                        complete,
   output logic [ROB_BITS-1:0]         rob_num_compl,
   output logic [PR_BITS-1:0]          p_rd_compl,
   output logic                        RegDest_compl,
   output logic                        changeFlow_compl,
   output logic [31:0]                 jb_addr_compl,
   output logic [$clog2(FIFO_DEPTH):0] alu_count,
   output logic [$clog2(FIFO_DEPTH):0] mem_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef struct packed {
      logic                ok;
      logic                cf;
      logic [31:0]         jb;
      logic                rd;
      logic [PR_BITS-1:0]  prd;
      logic [ROB_BITS-1:0] rob;
   } ent_t;
   ent_t                fifo_q [2][FIFO_DEPTH];
   ent_t                in_e [2];
   ent_t                head [2];
   ent_t                win_e;
   logic [1:0]          in_v, rdy, cand, push, pop;
   logic [CW-1:0]       cnt_q [2];
   logic [CW-1:0]       cnt_d [2];
   logic [PW-1:0]       wp_q [2];
   logic [PW-1:0]       wp_d [2];
   logic [PW-1:0]       rp_q [2];
   logic [PW-1:0]       rp_d [2];
   logic                rr_q, rr_d, prio, win_alu, go;
   logic                compl_q, rd_q, cf_q;
   logic [ROB_BITS-1:0] rob_q;
   logic [PR_BITS-1:0]  prd_q;
   logic [31:0]         jb_q;
   always_comb begin
      in_e[0] = '{ok: 1'b1, cf: alu_changeFlow, jb: alu_jb_addr, rd: alu_RegDest, prd: alu_p_rd, rob: alu_rob_num};
      in_e[1] = '{ok: 1'b1, cf: 1'b0, jb: '0, rd: mem_RegDest, prd: mem_p_rd, rob: mem_rob_num};
      in_v = {mem_valid, alu_valid};
      for (int g = 0; g < 2; g++) begin
         head[g] = fifo_q[g][rp_q[g]];
         rdy[g]  = cnt_q[g] < CW'(FIFO_DEPTH);
         // a head being squashed this cycle must not complete; it drains silently later
         cand[g] = (cnt_q[g] != '0) && !(recover && head[g].rob == flush_rob_num);
         push[g] = in_v[g] && rdy[g] && !(recover && in_e[g].rob == flush_rob_num);
      end
`ifdef COMPL_BRANCH_PRIO_EN
      prio = cand[0] && head[0].cf;
`else
      prio = 1'b0;
`endif
      win_alu = cand[0] && (!cand[1] || !rr_q || prio);
      pop     = {cand[1] && !win_alu, win_alu};
      rr_d    = (&cand && !prio) ? !rr_q : rr_q;
      win_e   = win_alu ? head[0] : head[1];
      go      = |pop && win_e.ok;
      for (int g = 0; g < 2; g++) begin
         cnt_d[g] = cnt_q[g] + CW'(push[g]) - CW'(pop[g]);
         wp_d[g]  = wp_q[g] + PW'(push[g]);
         rp_d[g]  = rp_q[g] + PW'(pop[g]);
      end
   end
   always_ff @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            if (recover && fifo_q[g][i].rob == flush_rob_num) fifo_q[g][i].ok <= 1'b0;
         if (push[g]) fifo_q[g][wp_q[g]] <= in_e[g];
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int g = 0; g < 2; g++) begin
            cnt_q[g] <= '0;
            wp_q[g]  <= '0;
            rp_q[g]  <= '0;
         end
         rr_q    <= 1'b0;
         compl_q <= 1'b0;
         rd_q    <= 1'b0;
         cf_q    <= 1'b0;
         rob_q   <= '0;
         prd_q   <= '0;
         jb_q    <= '0;
      end else begin
         for (int g = 0; g < 2; g++) begin
            cnt_q[g] <= cnt_d[g];
            wp_q[g]  <= wp_d[g];
            rp_q[g]  <= rp_d[g];
         end
         rr_q    <= rr_d;
         compl_q <= go;
         rd_q    <= go && win_e.rd;
         cf_q    <= go && win_e.cf;
         if (go) begin
            rob_q <= win_e.rob;
            prd_q <= win_e.prd;
            jb_q  <= win_e.jb;
         end
      end
   end
   assign alu_ready        = rdy[0];
   assign mem_ready        = rdy[1];
   assign alu_count        = cnt_q[0];
   assign mem_count        = cnt_q[1];
   assign complete         = compl_q;
   assign rob_num_compl    = rob_q;
   assign p_rd_compl       = prd_q;
   assign RegDest_compl    = rd_q;
   assign changeFlow_compl = cf_q;
   assign jb_addr_compl    = jb_q;
endmodule
